// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, sequencer states,
// instruction classes and the small decode helpers used by the sequencer.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        sRst, sT0, sT1, sT2, sT3, sT4, sT5, sT6, sT7, sHalt
    } ctrlState_t;

    typedef enum logic [3:0] {
        clsRAlu, clsIAlu, clsLdi, clsLd, clsSt, clsMulDiv, clsBr, clsNop, clsHalt
    } opClass_t;

    // True when st is the last execute step of the class; stop is honoured here.
    function automatic logic isFinalState(input opClass_t cls, input ctrlState_t st);
        case (cls)
            clsRAlu, clsIAlu, clsLdi: return st == sT5;
            clsLd, clsSt:             return st == sT7;
            clsMulDiv, clsBr:         return st == sT6;
            default:                  return 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] immAluOp(input logic [4:0] opcode);
        case (opcode)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/op_class_decode.sv
// Maps the IR opcode field to the instruction class that selects the
// execute sequence; anything not recognised behaves as a nop.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output opClass_t   opClass
);

    // NOTE: assigning a default before the case keeps this purely combinational
    // (no latch) even for opcodes no branch lists.
    always_comb begin
        opClass = clsNop;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: opClass = clsRAlu;
            OP_ADDI, OP_ANDI, OP_ORI:       opClass = clsIAlu;
            OP_LDI:                         opClass = clsLdi;
            OP_LD:                          opClass = clsLd;
            OP_ST:                          opClass = clsSt;
            OP_MUL, OP_DIV:                 opClass = clsMulDiv;
            OP_BR:                          opClass = clsBr;
            OP_HALT:                        opClass = clsHalt;
            default:                        opClass = clsNop;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch (T0-T2), opcode-class execute steps
// (T3-T7), and a HALT state left only through clr.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        PCout,
    output logic        ZHighout,
    output logic        ZLowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  operation,
    output logic        Run
);

    ctrlState_t state, nextState;
    opClass_t   opClass;
    logic [4:0] opcode;
    logic       unusedIrBits;

    assign opcode       = ir[31:27];
    assign unusedIrBits = ^ir[26:0];

    op_class_decode uDecode (
        .opcode  (opcode),
        .opClass (opClass)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of nextState.
    always_ff @(posedge clk) begin
        if (clr) state <= sRst;
        else     state <= nextState;
    end

    always_comb begin
        {PCout, ZHighout, ZLowout, MDRout, Cout, BAout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin} = '0;
        {Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write} = '0;
        operation = 5'b00000;
        Run       = 1'b1;
        nextState = state;

        case (state)
            sRst: nextState = sT0;

            sT0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
                nextState = sT1;
            end

            sT1: begin
                ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                nextState = sT2;
            end

            sT2: begin
                MDRout = 1'b1; IRin = 1'b1;
                if (opClass == clsHalt)     nextState = sHalt;
                else if (opClass == clsNop) nextState = sT0;
                else                        nextState = sT3;
            end

            sT3: begin
                case (opClass)
                    clsRAlu, clsIAlu:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    clsLdi, clsLd, clsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    clsMulDiv:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    clsBr:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    default: ;
                endcase
                nextState = sT4;
            end

            sT4: begin
                case (opClass)
                    clsRAlu: begin
                        Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode;
                    end
                    clsIAlu: begin
                        Cout = 1'b1; ZLOin = 1'b1; operation = immAluOp(opcode);
                    end
                    clsLdi, clsLd, clsSt: begin
                        Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD;
                    end
                    clsMulDiv: begin
                        Grb = 1'b1; Rout = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1;
                        operation = opcode;
                    end
                    clsBr:   begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
                nextState = sT5;
            end

            sT5: begin
                case (opClass)
                    clsRAlu, clsIAlu, clsLdi: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    clsLd, clsSt:  begin ZLowout = 1'b1; MARin = 1'b1; end
                    clsMulDiv:     begin ZLowout = 1'b1; LOin = 1'b1; end
                    clsBr:         begin Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD; end
                    default: ;
                endcase
                if (isFinalState(opClass, state)) nextState = stop ? sHalt : sT0;
                else                              nextState = sT6;
            end

            sT6: begin
                case (opClass)
                    clsLd:     begin Read = 1'b1; MDRin = 1'b1; end
                    clsSt:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    clsMulDiv: begin ZHighout = 1'b1; HIin = 1'b1; end
                    clsBr:     begin ZLowout = con_ff; PCin = con_ff; end
                    default: ;
                endcase
                if (isFinalState(opClass, state)) nextState = stop ? sHalt : sT0;
                else                              nextState = sT7;
            end

            sT7: begin
                case (opClass)
                    clsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    clsSt:   Write = 1'b1;
                    default: ;
                endcase
                nextState = stop ? sHalt : sT0;
            end

            sHalt: Run = 1'b0;

            default: nextState = sRst;
        endcase
    end

endmodule
